// File: rtl/mem_arbiter.sv
// Two-port (CPU / device) arbiter in front of a single RAM port.
// Round-robin grant, latched request, WAIT extra access cycles, one-cycle ack.
module mem_arbiter #(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dev_req,
  input  logic          dev_we,
  input  logic          dev_be,
  input  logic [AW-1:0] dev_addr,
  input  logic [DW-1:0] dev_wdata,
  output logic [DW-1:0] dev_rdata,
  output logic          dev_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          ram_be,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = (WAIT < 1) ? 1 : $clog2(WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;

  // On a tie the port that does not currently own the RAM wins.
  logic          w_any, w_gnt_dev;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_we, w_be;

  assign w_any     = cpu_req | dev_req;
  assign w_gnt_dev = dev_req & (~cpu_req | ~owner);
  assign w_addr    = w_gnt_dev ? dev_addr  : cpu_addr;
  assign w_wdata   = w_gnt_dev ? dev_wdata : cpu_wdata;
  assign w_we      = w_gnt_dev ? dev_we    : cpu_we;
  assign w_be      = w_gnt_dev ? dev_be    : cpu_be;

  // ram_* double as the latched request, so they stay stable through ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_be    <= 1'b0;
      ram_wdata <= '0;
      cpu_rdata <= '0;
      dev_rdata <= '0;
      cpu_ack   <= 1'b0;
      dev_ack   <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          ram_we <= 1'b0;
          if (w_any) begin
            owner     <= w_gnt_dev;
            ram_addr  <= w_addr;
            ram_wdata <= w_wdata;
            ram_be    <= w_be;
            ram_we    <= w_we;
            r_we      <= w_we;
            r_cnt     <= CW'(WAIT);
            busy      <= 1'b1;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            ram_we <= 1'b0;
            if (!r_we) begin
              if (owner) dev_rdata <= ram_rdata;
              else       cpu_rdata <= ram_rdata;
            end
            if (owner) dev_ack <= 1'b1;
            else       cpu_ack <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          cpu_ack <= 1'b0;
          dev_ack <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a WAIT=1 instance and a WAIT=0 instance,
// each with its own small RAM model.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WAIT=1 instance
  logic          cpu_req = 0, cpu_we = 0, cpu_be = 0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dev_req = 0, dev_we = 0, dev_be = 0;
  logic [AW-1:0] dev_addr = '0;
  logic [DW-1:0] dev_wdata = '0;
  logic [DW-1:0] cpu_rdata, dev_rdata, ram_wdata, ram_rdata;
  logic          cpu_ack, dev_ack, ram_we, ram_be, busy, owner;
  logic [AW-1:0] ram_addr;

  // WAIT=0 instance
  logic          z_cpu_req = 0, z_cpu_we = 0, z_cpu_be = 0;
  logic [AW-1:0] z_cpu_addr = '0;
  logic [DW-1:0] z_cpu_wdata = '0;
  logic          z_dev_req = 0, z_dev_we = 0, z_dev_be = 0;
  logic [AW-1:0] z_dev_addr = '0;
  logic [DW-1:0] z_dev_wdata = '0;
  logic [DW-1:0] z_cpu_rdata, z_dev_rdata, z_ram_wdata, z_ram_rdata;
  logic          z_cpu_ack, z_dev_ack, z_ram_we, z_ram_be, z_busy, z_owner;
  logic [AW-1:0] z_ram_addr;

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(1)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dev_req(dev_req), .dev_we(dev_we), .dev_be(dev_be), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_be(z_cpu_be), .cpu_addr(z_cpu_addr),
    .cpu_wdata(z_cpu_wdata), .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack),
    .dev_req(z_dev_req), .dev_we(z_dev_we), .dev_be(z_dev_be), .dev_addr(z_dev_addr),
    .dev_wdata(z_dev_wdata), .dev_rdata(z_dev_rdata), .dev_ack(z_dev_ack),
    .ram_addr(z_ram_addr), .ram_we(z_ram_we), .ram_be(z_ram_be), .ram_wdata(z_ram_wdata),
    .ram_rdata(z_ram_rdata), .busy(z_busy), .owner(z_owner)
  );

  // RAM models with a preload port so each array has a single writer process.
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem0 [256];
  logic          pl_wr1 = 0, pl_wr0 = 0;
  logic [7:0]    pl_a = '0;
  logic [DW-1:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_wr1)      mem1[pl_a] <= pl_d;
    else if (ram_we) mem1[ram_addr[7:0]] <= ram_wdata;
  end
  always @(posedge clk) begin
    if (pl_wr0)        mem0[pl_a] <= pl_d;
    else if (z_ram_we) mem0[z_ram_addr[7:0]] <= z_ram_wdata;
  end
  assign ram_rdata   = mem1[ram_addr[7:0]];
  assign z_ram_rdata = mem0[z_ram_addr[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit which0, input logic [7:0] a, input logic [DW-1:0] d);
    pl_a = a;
    pl_d = d;
    if (which0) pl_wr0 = 1'b1;
    else        pl_wr1 = 1'b1;
    tick();
    pl_wr0 = 1'b0;
    pl_wr1 = 1'b0;
  endtask

  initial begin
    int  last, nack, done_cyc, idx;
    bit  exp_dev, seen;

    // Preload while reset holds both arbiters idle.
    preload(0, 8'h10, 16'hBEEF);
    preload(0, 8'h20, 16'h0000);
    preload(0, 8'h30, 16'h0000);
    preload(0, 8'h40, 16'hAAAA);
    preload(0, 8'h41, 16'h5555);
    preload(1, 8'h05, 16'hCAFE);
    for (int i = 0; i < 4; i++) preload(1, 8'(i), 16'h0000);

    chk("rst_ram_we",  ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_owner",   owner, 1);
    chk("rst_acks",    {cpu_ack, dev_ack}, 0);
    chk("rst_rdata",   {cpu_rdata, dev_rdata}, 0);
    chk("rst_owner_w0", z_owner, 1);
    reset = 1'b0;
    tick();

    // CPU read, WAIT=1
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    chk("rd_acc1_addr", ram_addr, 16'h0010);
    chk("rd_acc1_busy", busy, 1);
    chk("rd_acc1_owner", owner, 0);
    chk("rd_acc1_ack", cpu_ack, 0);
    tick();
    chk("rd_acc2_addr", ram_addr, 16'h0010);
    chk("rd_acc2_ack", cpu_ack, 0);
    tick();
    chk("rd_done_ack", {cpu_ack, dev_ack}, 2'b10);
    chk("rd_rdata", cpu_rdata, 16'hBEEF);
    cpu_req = 0;
    tick();
    chk("rd_ack_pulse", cpu_ack, 0);
    chk("rd_idle_busy", busy, 0);

    // Device write, WAIT=1
    dev_req = 1; dev_we = 1; dev_addr = 16'h0020; dev_wdata = 16'h1234;
    tick();
    chk("wr_we1", ram_we, 1);
    chk("wr_owner", owner, 1);
    tick();
    chk("wr_we2", ram_we, 1);
    chk("wr_ack_early", dev_ack, 0);
    tick();
    chk("wr_we_done", ram_we, 0);
    chk("wr_done_ack", {cpu_ack, dev_ack}, 2'b01);
    chk("wr_rdata_kept", dev_rdata, 0);
    dev_req = 0; dev_we = 0;
    tick();
    chk("wr_mem", mem1[8'h20], 16'h1234);
    chk("wr_ack_pulse", dev_ack, 0);

    // Address change mid-access
    cpu_req = 1; cpu_addr = 16'h0040;
    tick();
    cpu_addr = 16'h0041;
    tick();
    chk("chg_addr", ram_addr, 16'h0040);
    tick();
    chk("chg_ack", cpu_ack, 1);
    chk("chg_rdata", cpu_rdata, 16'hAAAA);
    cpu_req = 0;
    tick();

    // Reset mid-access with a write in flight
    dev_req = 1; dev_we = 1; dev_addr = 16'h0030; dev_wdata = 16'h7777;
    tick();
    chk("mid_we", ram_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_owner", owner, 1);
    dev_req = 0; dev_we = 0;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cpu_ack || dev_ack || busy) seen = 1;
    end
    chk("mid_no_ack", seen, 0);
    chk("mid_mem", mem1[8'h30], 16'h0000);

    // Both requesting continuously from reset: CPU, dev, CPU, dev
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    dev_req = 1; dev_we = 0; dev_addr = 16'h0020;
    last = 0; nack = 0; exp_dev = 0;
    for (int c = 1; c <= 40 && nack < 4; c++) begin
      tick();
      if (cpu_ack || dev_ack) begin
        chk("rr_port", {cpu_ack, dev_ack}, exp_dev ? 2'b01 : 2'b10);
        chk("rr_gap", c - last, (nack == 0) ? 3 : 4);
        last = c;
        nack++;
        exp_dev = ~exp_dev;
      end
    end
    chk("rr_count", nack, 4);
    cpu_req = 0; dev_req = 0;
    chk("rr_cpu_rdata", cpu_rdata, 16'hBEEF);
    chk("rr_dev_rdata", dev_rdata, 16'h1234);
    tick();

    // WAIT=0: single read
    z_cpu_req = 1; z_cpu_we = 0; z_cpu_addr = 16'h0005;
    tick();
    chk("w0_acc_addr", z_ram_addr, 16'h0005);
    chk("w0_acc_ack", z_cpu_ack, 0);
    tick();
    chk("w0_ack", z_cpu_ack, 1);
    chk("w0_rdata", z_cpu_rdata, 16'hCAFE);
    z_cpu_req = 0;
    tick();
    chk("w0_idle", {z_cpu_ack, z_busy}, 0);

    // WAIT=0: back-to-back writes to 0..3
    z_cpu_req = 1; z_cpu_we = 1; z_cpu_addr = 16'h0000; z_cpu_wdata = 16'h1000;
    idx = 0; done_cyc = 0;
    for (int c = 1; c <= 40 && idx < 4; c++) begin
      tick();
      if (z_cpu_ack) begin
        idx++;
        if (idx == 4) done_cyc = c;
        else begin
          z_cpu_addr  = AW'(idx);
          z_cpu_wdata = DW'(16'h1000 + idx);
        end
      end
    end
    z_cpu_req = 0; z_cpu_we = 0;
    chk("w0_b2b_last_ack", done_cyc, 11);
    tick();
    chk("w0_b2b_idle", z_busy, 0);
    for (int i = 0; i < 4; i++)
      chk("w0_b2b_mem", mem0[i], 32'h1000 + i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
